seq_hit_logger: RTL and testbench

- Downstream consumer of the 1011 sequence detector's one-cycle `seq_seen` pulse.
- Keeps a free-running bit-position counter and timestamps each detection with the position at which `seq_seen` was high.
- Buffers timestamps in a small first-word-fall-through FIFO for a host to read by handshake.
- Also keeps a saturating total-hit count and a sticky overflow flag.

---
 rtl/seq_hit_logger.sv | 109 ++++++++++
 tb/tb_seq_hit_logger.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_hit_logger.sv
`default_nettype none
// ============================================================================
// Module   : seq_hit_logger
// Brief    : Timestamps sequence-detector hits with a free-running bit position
//            and queues them in a FWFT FIFO; saturating hit count, sticky drop flag.
// Revision : 1.0
// ============================================================================
module seq_hit_logger #(
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int HIT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seq_seen,
    input  logic             rd_en,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [HIT_W-1:0] hit_count
);

    localparam logic [ADDR_W:0]  c_full_count = (ADDR_W + 1)'(DEPTH);
    localparam logic [HIT_W-1:0] c_hit_max    = {HIT_W{1'b1}};

    logic [CNT_W-1:0]  r_pos;
    logic [CNT_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic [HIT_W-1:0]  r_hit_count;

    logic              w_hit;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_nxt;

    assign w_hit  = enable & seq_seen;
    assign w_pop  = rd_en & ~r_empty;
    // A full FIFO still accepts a hit when the head leaves in the same cycle.
    assign w_push = w_hit & (~r_full | w_pop);
    assign w_drop = w_hit & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR_W + 1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_hit_count <= '0;
        end else begin
            if (enable) begin
                r_pos <= r_pos + CNT_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_full_count);
            if (w_hit && (r_hit_count != c_hit_max)) begin
                r_hit_count <= r_hit_count + HIT_W'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_pos;
        end
    end

    assign rd_data   = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_hit_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_hit_logger
// Brief    : Directed self-checking bench for seq_hit_logger.
// Revision : 1.0
// ============================================================================
module tb_seq_hit_logger;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       seq_seen;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       overflow;
    logic [7:0] hit_count;

    int         n_checks;
    int         n_fails;
    logic [7:0] exp_pos;

    seq_hit_logger #(
        .CNT_W  (8),
        .DEPTH  (4),
        .ADDR_W (2),
        .HIT_W  (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seq_seen  (seq_seen),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .hit_count (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        if (enable) exp_pos = exp_pos + 8'd1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp_pos  = 8'd0;
        reset    = 1'b0;
        enable   = 1'b0;
        seq_seen = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;

        // 1: reset asserted mid-cycle, then first hit at pos 5
        #3 reset = 1'b1;
        #1;
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_hits", hit_count, 0);
        check_val("rst_rdata", rd_data, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("no_hit_empty", empty, 1);
        seq_seen = 1'b1;
        tick();
        seq_seen = 1'b0;
        check_val("first_empty", empty, 0);
        check_val("first_rdata", rd_data, 5);
        check_val("first_hits", hit_count, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("first_pop_empty", empty, 1);

        // 2: back-to-back fill from pos 10, fifth hit dropped
        while (exp_pos != 8'd10) tick();
        seq_seen = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        seq_seen = 1'b0;
        enable   = 1'b0;
        check_val("fill_full", full, 1);
        check_val("fill_ovf", overflow, 1);
        check_val("fill_hits", hit_count, 6);
        check_val("fill_head", rd_data, 10);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_val("clr_ovf", overflow, 0);

        // 3: drain six times from full
        for (int i = 0; i < 6; i++) begin
            if (i < 4) check_val("drain_data", rd_data, 10 + i);
            rd_en = 1'b1;
            tick();
            if (i == 3) check_val("drain_empty4", empty, 1);
        end
        rd_en = 1'b0;
        check_val("drain_empty", empty, 1);
        check_val("drain_full", full, 0);
        check_val("drain_rdata0", rd_data, 0);

        // 4a: refill (pos 15..18), then push+pop while full
        enable   = 1'b1;
        seq_seen = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("refill_full", full, 1);
        rd_en = 1'b1;
        tick();
        seq_seen = 1'b0;
        rd_en    = 1'b0;
        enable   = 1'b0;
        check_val("pp_full", full, 1);
        check_val("pp_ovf", overflow, 0);
        check_val("pp_head", rd_data, 16);
        check_val("pp_hits", hit_count, 11);
        for (int i = 0; i < 4; i++) begin
            check_val("pp_drain", rd_data, 16 + i);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check_val("pp_drained", empty, 1);

        // 4b: push+pop while empty at pos 20
        enable   = 1'b1;
        seq_seen = 1'b1;
        rd_en    = 1'b1;
        tick();
        enable   = 1'b0;
        seq_seen = 1'b0;
        check_val("ppe_empty", empty, 0);
        check_val("ppe_data", rd_data, 20);
        tick();
        rd_en = 1'b0;
        check_val("ppe_pop", empty, 1);

        // 5: enable gating, then wrap 255 -> 0
        seq_seen = 1'b1;
        tick();
        tick();
        seq_seen = 1'b0;
        check_val("gate_empty", empty, 1);
        check_val("gate_hits", hit_count, 12);
        enable = 1'b1;
        while (exp_pos != 8'd255) tick();
        seq_seen = 1'b1;
        tick();
        tick();
        seq_seen = 1'b0;
        enable   = 1'b0;
        check_val("wrap_255", rd_data, 255);
        rd_en = 1'b1;
        tick();
        check_val("wrap_0", rd_data, 0);
        check_val("wrap_nonempty", empty, 0);
        tick();
        rd_en = 1'b0;
        check_val("wrap_hits", hit_count, 14);

        // 6: 300 hits with continuous popping, from pos 1
        enable   = 1'b1;
        seq_seen = 1'b1;
        rd_en    = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check_val("sat_hits", hit_count, 255);
        check_val("sat_ovf", overflow, 0);
        check_val("sat_head", rd_data, 44);
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_val("sat_full", full, 1);
        clr_ovf = 1'b1;
        tick();
        check_val("drop_clr_ovf", overflow, 1);
        check_val("sat_hold", hit_count, 255);
        seq_seen = 1'b0;
        tick();
        clr_ovf = 1'b0;
        check_val("clr_after", overflow, 0);

        // mid-operation asynchronous reset with a full FIFO
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_empty", empty, 1);
        check_val("mid_rst_full", full, 0);
        check_val("mid_rst_hits", hit_count, 0);
        check_val("mid_rst_rdata", rd_data, 0);
        enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
